uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Serial receive front end of the vector accelerator; sits directly upstream of the input command FIFO and feeds it the bytes that drive in_bus.
- Synchronises the asynchronous rx pin, detects and validates start bits, samples 8N1 frames at mid-bit, and presents each byte on a valid/ready interface.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 10_000_000, serial bit rate in bits/s.
- CLK_PER_BIT, CLK_FREQ/BAUD, clock cycles per bit. Derived; not overridden independently. Elaboration fails if less than 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, idle high, LSB first, 8 data bits, 1 stop bit, no parity.
- data  out  8  received byte; stable while valid=1.
- valid  out  1  data holds an unconsumed byte.
- ready  in  1  downstream (input FIFO) can accept data.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while the previous byte was still held.

Behaviour:
- Reset values:
  - data=0, valid=0, frame_err=0, overrun=0.
  - Synchroniser flops=1. FSM=IDLE. Bit counter and cycle counter =0.
  - Reset asserted mid-frame abandons the frame; no partial byte is ever output.
- Input sync: two-flop synchroniser on rx. All logic uses the synchronised rx_s, which lags the pin by 2 cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s==0, go to START and clear the cycle counter.
  - START: count CLK_PER_BIT/2 cycles (integer divide) to reach mid start bit.
    - rx_s==0 there: go to DATA, clear the bit index.
    - rx_s==1 there: glitch. Return to IDLE with no output and no error.
  - DATA: count CLK_PER_BIT cycles, then sample rx_s into shift[bit_index] (LSB first).
    - After bit 7, go to STOP.
  - STOP: count CLK_PER_BIT cycles, then sample rx_s at mid stop bit.
    - rx_s==1: frame complete (see output rules below). Return to IDLE immediately at mid stop bit, so a start bit directly following the stop bit is caught.
    - rx_s==0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- Output handshake:
  - A transfer occurs on a cycle with valid&&ready. valid drops the next cycle unless a new byte completes in that same cycle.
  - Frame completes while valid==0, or while valid&&ready in the same cycle: load data, set valid=1. No overrun.
  - Frame completes while valid==1 and ready==0: pulse overrun for 1 cycle, drop the new byte, and keep data/valid unchanged.
  - data never changes while valid==1 and no transfer occurs.
- Latency:
  - Start-bit falling edge at the pin to valid rising is 2 + CLK_PER_BIT/2 + 9*CLK_PER_BIT + 1 cycles.
  - At defaults: 2 + 5 + 90 + 1 = 98 cycles, ±1 cycle for pin/clock phase.
- Throughput: sustains back-to-back frames at full baud with ready held high. No bytes are lost.
- Counters: cycle counter width is clog2(CLK_PER_BIT)+1. Bit index is 3 bits and must not wrap past 7 into a 9th sample.
- rx changes arriving during DATA/STOP between sample points are ignored; only mid-bit samples matter.

Test Plan:
- Reset then idle: rst high 100 ns, rx=1 for 2 µs -> valid, frame_err and overrun stay 0; data=0x00.
- Single byte: send 0x10 at 100 ns/bit with ready=1 -> valid pulses for exactly 1 cycle with data=0x10, 98±1 cycles after the start edge.
- Back-to-back: send 0x10,0x00,0x03,0x19,0xE0,0x07,0x80,0xF0 with no gap and ready=1 -> 8 valid pulses, bytes in order, no errors.
- Glitch and framing:
  - rx low for 3 cycles, then high -> no valid, no frame_err.
  - Then a frame 0x55 with stop bit=0 -> one frame_err pulse, no valid.
  - Then rx=1 and send 0xA5 -> data=0xA5 with valid.
- Overrun and simultaneity:
  - ready=0, send 0x11 then 0x22 -> valid held with data=0x11 and 1 overrun pulse at the 0x22 stop bit. Raise ready -> 0x11 transferred, valid drops.
  - Repeat with ready asserted exactly on the cycle 0x22 completes -> 0x22 loaded, no overrun.
- Reset mid-frame: assert rst during bit 4 of 0xC3, release, send 0x3C -> only 0x3C is output, no errors.

Source files
------------

// File: rtl/uart_rx_deframer_if.sv
// Byte handshake between the UART deframer and the input command FIFO.
// The master drives data/valid and the slave answers with ready.
interface uart_rx_deframer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: synchronises rx, samples mid-bit and
// hands bytes downstream on valid/ready, flagging framing/overrun.
module uart_rx_deframer #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  uart_rx_deframer_if.master rx_if,
  output logic frame_err,
  output logic overrun
);

  localparam int CLK_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT    = CLK_PER_BIT / 2;
  localparam int CW          = $clog2(CLK_PER_BIT) + 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLK_PER_BIT - 1);

  generate
    if (CLK_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx_deframer: CLK_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;

  logic            w_rx_s;
  logic            w_xfer;

  assign w_rx_s = r_sync[1];
  assign w_xfer = r_valid && rx_if.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (w_xfer) begin
        r_valid <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state <= DATA;
              r_bit   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == BIT_M1) begin
            r_cnt          <= '0;
            r_shift[r_bit] <= w_rx_s;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == BIT_M1) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              // leave at mid stop bit so an abutting start bit is caught
              r_state <= IDLE;
              if (r_valid && !rx_if.ready) begin
                r_overrun <= 1'b1;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (w_rx_s) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_if.data  = r_data;
  assign rx_if.valid = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer at 100 MHz / 10 Mbaud.
// Bytes expected downstream go through a scoreboard queue.
module tb_uart_rx_deframer;

  localparam int BITC = 10;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic frame_err;
  logic overrun;

  uart_rx_deframer_if bus ();

  uart_rx_deframer dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_if     (bus.master),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_vhigh = 0;
  int rise_cyc = -1;
  int start_cyc = 0;
  logic prev_v = 1'b0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         gap;
    int         exp_fe;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] e;
    #1;
    if (bus.valid && !prev_v) rise_cyc = cyc;
    prev_v = bus.valid;
    if (bus.valid) n_vhigh++;
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (bus.valid && bus.ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.data);
      end else begin
        e = q.pop_front();
        check("byte", {24'h0, bus.data}, {24'h0, e});
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITC) @(negedge clk);
    end
    rx = stop;
    repeat (BITC) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int fe0, ov0, vh0, d;

    tbl[0] = '{8'h10, 1'b1, 0, 0};
    tbl[1] = '{8'h00, 1'b1, 0, 0};
    tbl[2] = '{8'h03, 1'b1, 0, 0};
    tbl[3] = '{8'h19, 1'b1, 0, 0};
    tbl[4] = '{8'hE0, 1'b1, 0, 0};
    tbl[5] = '{8'h07, 1'b1, 0, 0};
    tbl[6] = '{8'h80, 1'b1, 0, 0};
    tbl[7] = '{8'hF0, 1'b1, 20, 0};
    tbl[8] = '{8'h55, 1'b0, 30, 1};
    tbl[9] = '{8'hA5, 1'b1, 10, 0};

    rst = 1'b1;
    rx = 1'b1;
    bus.ready = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_valid", {31'h0, bus.valid}, 0);
    check("rst_data", {24'h0, bus.data}, 0);
    rst = 1'b0;

    repeat (200) @(negedge clk);
    check("idle_valid_cnt", n_vhigh, 0);
    check("idle_fe", n_fe, 0);
    check("idle_ov", n_ov, 0);
    check("idle_data", {24'h0, bus.data}, 0);

    n_vhigh = 0;
    rise_cyc = -1;
    q.push_back(8'h10);
    send_frame(8'h10, 1'b1);
    repeat (5) @(negedge clk);
    d = rise_cyc - start_cyc;
    check("latency_ok", {31'h0, (d >= 97 && d <= 99)}, 1);
    if (d < 97 || d > 99) $display("latency measured %0d cycles", d);
    check("single_pulse_len", n_vhigh, 1);
    check("single_drained", q.size(), 0);

    vh0 = n_vhigh;
    fe0 = n_fe;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_valid", n_vhigh - vh0, 0);
    check("glitch_fe", n_fe - fe0, 0);

    for (int i = 0; i < 10; i++) begin
      fe0 = n_fe;
      if (tbl[i].stop) q.push_back(tbl[i].b);
      send_frame(tbl[i].b, tbl[i].stop);
      check("vec_fe", n_fe - fe0, tbl[i].exp_fe);
      check("vec_drained", q.size(), 0);
      repeat (tbl[i].gap) @(negedge clk);
    end
    check("vec_ov", n_ov, 0);

    bus.ready = 1'b0;
    ov0 = n_ov;
    q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    check("ovr_pulse", n_ov - ov0, 1);
    check("ovr_valid_held", {31'h0, bus.valid}, 1);
    check("ovr_data_held", {24'h0, bus.data}, 32'h11);
    bus.ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_valid_drop", {31'h0, bus.valid}, 0);
    check("ovr_drained", q.size(), 0);

    bus.ready = 1'b0;
    ov0 = n_ov;
    q.push_back(8'h11);
    q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (97) @(negedge clk);
        bus.ready = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    check("simul_no_ov", n_ov - ov0, 0);
    check("simul_drained", q.size(), 0);
    check("simul_valid", {31'h0, bus.valid}, 0);

    fe0 = n_fe;
    ov0 = n_ov;
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[0] ^ d[0] ^ ((8'hC3 >> i) & 1);
      repeat (BITC) @(negedge clk);
    end
    rx = 1'b0;
    repeat (BITC / 2) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_valid", {31'h0, bus.valid}, 0);
    check("midrst_data", {24'h0, bus.data}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    check("midrst_drained", q.size(), 0);
    check("midrst_fe", n_fe - fe0, 0);
    check("midrst_ov", n_ov - ov0, 0);
    check("midrst_data_out", {24'h0, bus.data}, 32'h3C);

    check("final_queue", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
